gpio_ctrl_apb_initiator: RTL

APB4 initiator (requester) that converts single commands on a valid/ready command channel into one APB transfer each and returns the result on a valid/ready response channel. It drives the APB side of the GPIO controller register blocks, including the interrupt status CSR, from the controller's test and sequencer logic. It adds a bounded wait-state timeout so that a responder that never answers cannot hang the requester.

---
 rtl/gpio_ctrl_pkg.sv | 14 +
 rtl/gpio_ctrl_apb_initiator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared types and constants for the GPIO controller APB logic.
package gpio_ctrl_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_init_state_e;

endpackage

// File: rtl/gpio_ctrl_apb_initiator.sv
// APB4 initiator: one command in, one APB transfer, one response out,
// with a bounded wait-state timeout on the ACCESS phase.
module gpio_ctrl_apb_initiator
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [APB_STRB_WIDTH-1:0] cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_STRB_WIDTH-1:0] pstrb,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned CNT_WIDTH =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  apb_init_state_e             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]       r_paddr, w_paddr_nxt;
  logic                        r_psel, w_psel_nxt;
  logic                        r_penable, w_penable_nxt;
  logic                        r_pwrite, w_pwrite_nxt;
  logic [APB_STRB_WIDTH-1:0]   r_pstrb, w_pstrb_nxt;
  logic [APB_DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic                        r_rsp_valid, w_rsp_valid_nxt;
  logic [APB_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                        r_rsp_err, w_rsp_err_nxt;
  logic                        r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CNT_WIDTH-1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic                        w_timeout_hit;

  // Wait limit reached; a zero limit never fires.
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (r_wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));

  assign cmd_ready   = (r_state == ST_IDLE) && !rst;
  assign paddr       = r_paddr;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign pstrb       = r_pstrb;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    w_state_nxt       = r_state;
    w_paddr_nxt       = r_paddr;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_pstrb_nxt       = r_pstrb;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_wait_cnt_nxt    = r_wait_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt    = cmd_addr;
          w_pwrite_nxt   = cmd_write;
          w_pwdata_nxt   = cmd_write ? cmd_wdata : '0;
          w_pstrb_nxt    = cmd_write ? cmd_strb : '0;
          w_psel_nxt     = 1'b1;
          w_penable_nxt  = 1'b0;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : prdata;
          w_rsp_err_nxt     = pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_state_nxt       = ST_RESP;
        end else if (w_timeout_hit) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_state_nxt       = ST_RESP;
        end else if (r_wait_cnt != {CNT_WIDTH{1'b1}}) begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pstrb       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_paddr       <= w_paddr_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_pstrb       <= w_pstrb_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

endmodule
